result_drain: RTL
=================

# result_drain

Downstream stage of the 3x3 systolic `control` block. It watches the controller's `o_done` and, on completion, captures the flat N×N result vector `o_C` into a local buffer. It then streams the N*N elements out one per handshake on a valid/ready interface. After the last element it drops the controller's enable for one cycle, which returns the controller to its idle state, ready for the next matrix product.

## Interface
Parameters:
- `W`, 16, element width in bits; must match `control`.
- `N`, 3, matrix dimension; the frame is N*N elements.
- `CNT_W`, 8, width of the frame counter.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_done`  in  1  controller `o_done`.
- `i_C`  in  W*N*N  controller `o_C`.
  - Element k = row*N+col occupies bits [(k+1)*W-1 : k*W].
- `o_ctrl_en`  out  1  drives controller `i_en`.
- `o_valid`  out  1  output element valid.
- `i_ready`  in  1  downstream accepts the element.
- `o_data`  out  W  current element.
- `o_last`  out  1  high with element k = N*N-1.
- `o_busy`  out  1  high in STREAM or REARM.
- `o_frames`  out  CNT_W  count of completed frames; wraps.

## Operation
- States: IDLE, STREAM, REARM.
- IDLE:
  - `o_ctrl_en`=1, `o_valid`=0.
  - When `i_done`=1 is sampled: latch all of `i_C` into the buffer, set idx=0, go to STREAM.
- STREAM:
  - `o_valid`=1, `o_data`=buffer[idx], `o_last`=(idx==N*N-1).
  - On `o_valid && i_ready`:
    - If idx<N*N-1: idx increments.
    - Otherwise: `o_frames` increments (wrapping, 2^CNT_W-1 → 0) and the state goes to REARM.
  - `i_ready` low holds idx, and `o_data`/`o_last` stay stable indefinitely.
  - `o_ctrl_en` stays 1 so the controller holds its done state.
  - `i_done` and `i_C` are ignored; the buffer is not overwritten.
- REARM:
  - `o_ctrl_en`=0 for exactly one cycle, `o_valid`=0; next state IDLE.
  - The controller synchronously clears its state on the low enable, so `i_done` is low by the first IDLE cycle.
- Outside STREAM: `o_data` and `o_last` are 0.
- `i_done` is evaluated only in IDLE. If it is high there, capture happens even if it has been high for several cycles.
- Element order is strictly ascending k; no reordering and no arithmetic on the data.

## Timing
- Reset (asynchronous assert; release synchronous to `i_clk`):
  - State IDLE, idx 0, buffer 0.
  - `o_ctrl_en`=0, `o_valid`=0, `o_data`=0, `o_last`=0, `o_busy`=0, `o_frames`=0.
- `o_ctrl_en` is registered; it first goes 1 on the first rising edge after reset release.
- Capture latency: `i_done` sampled high at edge t → `o_valid`=1 from edge t+1.
- With `i_ready` held at 1: elements k=0..N*N-1 occupy cycles t+1..t+N*N, REARM occupies t+N*N+1, and IDLE resumes at t+N*N+2.
- Minimum frame-to-frame spacing at the drain: N*N+2 cycles, plus the controller's compute time.
- Reset mid-STREAM: the frame is discarded, `o_valid` falls immediately (asynchronously), and `o_frames` is not incremented.
- `i_ready` may be high before `o_valid`; a handshake only occurs in cycles where both are 1.

## Structure
- Shared package `systolic_pkg`:
  - Default `W` and `N`.
  - The state encoding (IDLE=2'd0, STREAM=2'd1, REARM=2'd2; 2'd3 recovers to IDLE).
  - A function returning the bit offset of element k.
- No sub-module is needed:
  - The buffer is a flat register loaded in one cycle.
  - The element mux is an indexed part-select on idx.
  - idx width is $clog2(N*N).

## Test plan
- Reset: hold `i_rst_n`=0 and toggle the clock → all outputs 0. Release → `o_ctrl_en`=1 after one edge, `o_valid`=0.
- Basic drain: W=16, N=3, `i_C` elements k=0..8 = 1..9, pulse `i_done`, `i_ready`=1:
  - `o_data`=1..9 on consecutive cycles, `o_last` only with 9.
  - `o_ctrl_en`=0 for one cycle after, `o_frames`=1.
- Backpressure: same frame, `i_ready`=0 for 5 cycles at k=4 → `o_data` holds 5 with `o_valid`=1, then 6..9 follow with no element lost or duplicated.
- Input isolation: change `i_C` to all 0xFFFF and hold `i_done`=1 during STREAM → output still 1..9. After REARM, one new capture yields 0xFFFF ×9.
- Wrap: CNT_W=2, drain 5 frames → `o_frames` sequence 1,2,3,0,1.
- Mid-stream reset: assert `i_rst_n`=0 at k=3 → `o_valid` drops asynchronously, `o_frames` stays 0. After release, a new `i_done` restarts at k=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, drain state encoding and element offset helper for the 3x3 systolic array
package systolic_pkg;
   localparam int SYS_W = 16;
   localparam int SYS_N = 3;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      REARM  = 2'd2
   } state_e;
   function automatic int unsigned elem_off(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction
endpackage

// File: rtl/result_drain.sv
// result_drain: captures the controller's flat result on done, streams it out one element per
// valid/ready handshake, then pulses the controller enable low for one cycle to rearm it.
module result_drain
   import systolic_pkg::*;
#(
   parameter int W     = SYS_W,
   parameter int N     = SYS_N,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_done,
   input  logic [W*N*N-1:0] i_C,
   output logic             o_ctrl_en,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [W-1:0]     o_data,
   output logic             o_last,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_frames
);
   localparam int NN = N * N;
   localparam int IW = (NN > 1) ? $clog2(NN) : 1;
   localparam logic [IW-1:0] LAST = IW'(NN - 1);
   state_e             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [W*NN-1:0]    buf_q, buf_d;
   logic [CNT_W-1:0]   frames_q, frames_d;
   logic               ctrl_en_q;
   logic [W-1:0]       data;
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      buf_d    = buf_q;
      frames_d = frames_q;
      case (state_q)
         IDLE: if (i_done) begin
            buf_d   = i_C;
            idx_d   = '0;
            state_d = STREAM;
         end
         STREAM: if (i_ready) begin
            if (idx_q == LAST) begin
               frames_d = frames_q + CNT_W'(1);
               state_d  = REARM;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         REARM:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // enable is registered off the next state so it is low exactly while REARM is held
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         buf_q     <= '0;
         frames_q  <= '0;
         ctrl_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         buf_q     <= buf_d;
         frames_q  <= frames_d;
         ctrl_en_q <= (state_d != REARM);
      end
   end
   always_comb begin
      data = '0;
      for (int k = 0; k < NN; k++)
         if (state_q == STREAM && idx_q == IW'(k)) data = buf_q[elem_off(k, W) +: W];
   end
   assign o_ctrl_en = ctrl_en_q;
   assign o_valid   = (state_q == STREAM);
   assign o_data    = data;
   assign o_last    = (state_q == STREAM) && (idx_q == LAST);
   assign o_busy    = (state_q == STREAM) || (state_q == REARM);
   assign o_frames  = frames_q;
endmodule
